// File: rtl/alu_ctrl_mc.sv
// -----------------------------------------------------------------------------
// alu_ctrl_mc
//
// ALU control decoder with a small sequencer for multi-cycle multiply/divide.
// Single-cycle operations decode combinationally from ALUOp_i/funct_i. A valid
// MULT/MULTU (and DIV/DIVU when enabled) is accepted in IDLE and stalls the
// pipeline for N step cycles, followed by a one-cycle DONE pulse.
//
// Build option:
//   ALU_CTRL_MC_DIV_EN  - when defined, DIV/DIVU decode and run DIV_CYCLES
//                         iterations; when undefined they decode as illegal.
//
// Parameters:
//   MUL_CYCLES  step cycles for MULT/MULTU (2..63)
//   DIV_CYCLES  step cycles for DIV/DIVU   (2..63)
//   CNT_W       iteration counter width, must hold max(cycles)-1
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   valid_i    funct_i/ALUOp_i carry a live instruction
//   funct_i    R-type function field
//   ALUOp_i    main-control ALU operation class
//   ALUCtrl_o  ALU operation select
//   busy_o     stall request while a multi-cycle op runs
//   step_o     per-iteration enable to the mul/div datapath
//   done_o     one-cycle pulse, multi-cycle result valid
//   illegal_o  valid_i with an undecodable ALUOp_i/funct_i
// -----------------------------------------------------------------------------
module alu_ctrl_mc #(
    parameter int MUL_CYCLES = 32,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [5:0] funct_i,
    input  logic [2:0] ALUOp_i,
    output logic [3:0] ALUCtrl_o,
    output logic       busy_o,
    output logic       step_o,
    output logic       done_o,
    output logic       illegal_o
);

    localparam logic [3:0] CODE_AND   = 4'b0000;
    localparam logic [3:0] CODE_OR    = 4'b0001;
    localparam logic [3:0] CODE_ADD   = 4'b0010;
    localparam logic [3:0] CODE_SLL   = 4'b0011;
    localparam logic [3:0] CODE_LUI   = 4'b0100;
    localparam logic [3:0] CODE_SLLV  = 4'b0101;
    localparam logic [3:0] CODE_SUB   = 4'b0110;
    localparam logic [3:0] CODE_SLT   = 4'b0111;
    localparam logic [3:0] CODE_MULT  = 4'b1000;
    localparam logic [3:0] CODE_MULTU = 4'b1001;
    localparam logic [3:0] CODE_ILL   = 4'b1111;

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;

    // Elaboration-time sanity check of the parameter set.
    if (MUL_CYCLES < 2 || MUL_CYCLES > 63 || DIV_CYCLES < 2 || DIV_CYCLES > 63 ||
        (MAX_CYCLES - 1) >= (1 << CNT_W)) begin : g_param_check
        $error("alu_ctrl_mc: illegal MUL_CYCLES/DIV_CYCLES/CNT_W combination");
    end

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
`ifdef ALU_CTRL_MC_DIV_EN
    localparam logic [3:0]       CODE_DIV  = 4'b1010;
    localparam logic [3:0]       CODE_DIVU = 4'b1011;
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       code, code_next;
    logic [3:0]       dec;
    logic             is_multi;
    logic [CNT_W-1:0] last_cnt;

    function automatic logic [3:0] funct_decode(input logic [5:0] funct);
        logic [3:0] c;
        case (funct)
            6'b100000: c = CODE_ADD;
            6'b100010: c = CODE_SUB;
            6'b100100: c = CODE_AND;
            6'b100101: c = CODE_OR;
            6'b101010: c = CODE_SLT;
            6'b000000: c = CODE_SLL;
            6'b000100: c = CODE_SLLV;
            6'b011000: c = CODE_MULT;
            6'b011001: c = CODE_MULTU;
`ifdef ALU_CTRL_MC_DIV_EN
            6'b011010: c = CODE_DIV;
            6'b011011: c = CODE_DIVU;
`endif
            default:   c = CODE_ILL;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] op_decode(input logic [2:0] alu_op, input logic [5:0] funct);
        logic [3:0] c;
        case (alu_op)
            3'b001:  c = CODE_SUB;
            3'b100:  c = CODE_ADD;
            3'b101:  c = CODE_SLT;
            3'b110:  c = CODE_LUI;
            3'b111:  c = CODE_OR;
            3'b010:  c = funct_decode(funct);
            default: c = CODE_ILL;
        endcase
        return c;
    endfunction

    assign dec = op_decode(ALUOp_i, funct_i);

    // Codes 10xx are the multi-cycle group; DIV codes never appear unless enabled.
    assign is_multi = (dec[3:2] == 2'b10);

`ifdef ALU_CTRL_MC_DIV_EN
    // code[1] separates 100x (multiply) from 101x (divide).
    assign last_cnt = code[1] ? DIV_LAST : MUL_LAST;
`else
    assign last_cnt = MUL_LAST;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            code  <= CODE_ILL;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            code  <= code_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        code_next  = code;
        ALUCtrl_o  = CODE_ILL;
        busy_o     = 1'b0;
        step_o     = 1'b0;
        done_o     = 1'b0;
        illegal_o  = 1'b0;

        // Outputs are held at their reset values for as long as rst_i is high,
        // even though the IDLE decode path is purely combinational.
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    ALUCtrl_o = dec;
                    illegal_o = valid_i && (dec == CODE_ILL);
                    if (valid_i && is_multi) begin
                        // The accept cycle is the first step cycle.
                        busy_o     = 1'b1;
                        step_o     = 1'b1;
                        code_next  = dec;
                        cnt_next   = CNT_W'(1);
                        state_next = RUN;
                    end
                end
                RUN: begin
                    busy_o    = 1'b1;
                    step_o    = 1'b1;
                    ALUCtrl_o = code;
                    cnt_next  = cnt + CNT_W'(1);
                    if (cnt == last_cnt) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    // The stalled instruction retires here; inputs are ignored.
                    done_o     = 1'b1;
                    ALUCtrl_o  = code;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule
